// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, collector state encoding and brev7 helper
package kyber_pkg;
    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEF_W  = 12;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } coll_state_t;

    function automatic logic [6:0] brev7(input logic [6:0] x);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = x[6-i];
        return r;
    endfunction
endpackage

// File: rtl/ntt_out_collector_if.sv
// rtl/ntt_out_collector_if.sv - pipeline pair input and serial coefficient output bundle
interface ntt_out_collector_if #(
    parameter int COEF_W = 12,
    parameter int IDX_W  = 8
);
    logic              mode;
    logic              in_valid;
    logic [COEF_W-1:0] i1;
    logic [COEF_W-1:0] i2;
    logic              out_valid;
    logic              out_ready;
    logic [COEF_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output mode, in_valid, i1, i2, out_ready,
        input  out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  mode, in_valid, i1, i2, out_ready,
        output out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/coef_bank.sv
// rtl/coef_bank.sv - simple dual-port coefficient RAM, one write port, one synchronous read port
module coef_bank #(
    parameter int DW    = 12,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Read register only moves on i_re, so it doubles as the stalled output holder.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ntt_out_collector.sv
// rtl/ntt_out_collector.sv - reorders the NTT/INTT pipeline pair stream into natural-order beats
// Optional: NTT_OUT_COLLECTOR_RANGE_CHECK_EN adds the sticky range_err output.
module ntt_out_collector
    import kyber_pkg::*;
#(
    parameter int COEF_W  = kyber_pkg::COEF_W,
    parameter int N_PAIRS = 128,
    parameter int IDX_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    ntt_out_collector_if.slave  bus,
    output logic                busy,
    output logic                overflow
`ifdef NTT_OUT_COLLECTOR_RANGE_CHECK_EN
    ,
    output logic                range_err
`endif
);
    localparam int AW = $clog2(N_PAIRS);

    coll_state_t       r_state;
    coll_state_t       w_state_nxt;
    logic [AW-1:0]     r_k;
    logic              r_mode;
    logic [IDX_W-1:0]  r_rd;
    logic              r_rd_done;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_out_bank;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_overflow;

    logic              w_wr_en;
    logic              w_mode_eff;
    logic [AW-1:0]     w_wr_addr;
    logic              w_k_last;
    logic              w_advance;
    logic              w_issue;
    logic              w_rd_bank;
    logic [AW-1:0]     w_rd_addr;
    logic              w_last_hs;
    logic [COEF_W-1:0] w_rdata0;
    logic [COEF_W-1:0] w_rdata1;

    // The mode pin only matters on the first pair; afterwards the latched copy rules.
    assign w_wr_en    = bus.in_valid && (r_state != ST_DRAIN);
    assign w_mode_eff = (r_state == ST_IDLE) ? bus.mode : r_mode;
    assign w_wr_addr  = (w_mode_eff == MODE_INTT) ? r_k : brev7(r_k);
    assign w_k_last   = (r_k == AW'(N_PAIRS - 1));

    assign w_advance  = !r_out_valid || bus.out_ready;
    assign w_issue    = (r_state == ST_DRAIN) && w_advance && !r_rd_done;
    assign w_rd_bank  = (r_mode == MODE_INTT) ? r_rd[IDX_W-1] : r_rd[0];
    assign w_rd_addr  = (r_mode == MODE_INTT) ? r_rd[AW-1:0] : r_rd[IDX_W-1:1];
    assign w_last_hs  = r_out_valid && bus.out_ready && r_out_last;

    coef_bank #(.DW(COEF_W), .DEPTH(N_PAIRS)) u_bank0 (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (bus.i1),
        .i_re    (w_issue),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata0)
    );

    coef_bank #(.DW(COEF_W), .DEPTH(N_PAIRS)) u_bank1 (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (bus.i2),
        .i_re    (w_issue),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata1)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.in_valid) w_state_nxt = ST_FILL;
            ST_FILL:  if (bus.in_valid && w_k_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_hs) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k         <= '0;
            r_mode      <= MODE_NTT;
            r_rd        <= '0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_bank  <= 1'b0;
            r_out_idx   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_k <= w_k_last ? '0 : r_k + 1'b1;
                if (r_state == ST_IDLE) r_mode <= bus.mode;
            end
            if (bus.in_valid && (r_state == ST_DRAIN)) r_overflow <= 1'b1;
            // Issue pointer runs one beat ahead of the presented beat.
            if ((r_state == ST_DRAIN) && w_advance) begin
                if (!r_rd_done) begin
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_rd;
                    r_out_last  <= (r_rd == '1);
                    r_out_bank  <= w_rd_bank;
                    r_rd        <= r_rd + 1'b1;
                    if (r_rd == '1) r_rd_done <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_rd_done   <= 1'b0;
                end
            end
        end
    end

`ifdef NTT_OUT_COLLECTOR_RANGE_CHECK_EN
    logic r_range_err;
    always_ff @(posedge clk) begin
        if (!rst)
            r_range_err <= 1'b0;
        else if (w_wr_en && ((bus.i1 >= COEF_W'(KYBER_Q)) || (bus.i2 >= COEF_W'(KYBER_Q))))
            r_range_err <= 1'b1;
    end
    assign range_err = r_range_err;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_valid ? (r_out_bank ? w_rdata1 : w_rdata0) : '0;
    assign busy          = (r_state != ST_IDLE);
    assign overflow      = r_overflow;
endmodule

// File: doc/ntt_out_collector.md
Name: ntt_out_collector

Overview:
- Sink end of the NTT/INTT butterfly pipeline.
- Captures the two-coefficient-per-cycle stream (o1/o2) leaving the last pipeline stage and undoes the pipeline output ordering.
- Stores one full 256-coefficient polynomial.
- Re-emits it serially in natural index order 0..255 over a valid/ready interface to the polynomial RAM / host side.

Parameters:
- COEF_W, 12, coefficient width.
- N_PAIRS, 128, input pairs per polynomial; 2*N_PAIRS coefficients out.
- IDX_W, 8, output index width, log2(2*N_PAIRS).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- mode  in  1  0=NTT, 1=INTT; sampled only on the first accepted pair of a polynomial.
- in_valid  in  1  i1/i2 carry a valid pair this cycle; no back-pressure exists.
- i1  in  COEF_W  first pipeline output (o1).
- i2  in  COEF_W  second pipeline output (o2).
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  COEF_W  coefficient value.
- out_idx  out  IDX_W  natural coefficient index.
- out_last  out  1  high with the beat at out_idx==255.
- busy  out  1  high in FILL or DRAIN.
- overflow  out  1  sticky: a pair arrived while it could not be stored.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, pair counter k=0, read counter r=0.
  - out_valid=0, out_last=0, busy=0, overflow=0; out_data/out_idx=0.
  - Buffer contents undefined, not cleared.
  - Reset mid-FILL or mid-DRAIN aborts the polynomial; there is no partial output.
- Storage: two banks (bank0 <- i1, bank1 <- i2), 128 x COEF_W each, written in the same cycle.
- Write address and resulting natural coefficient index, per mode:
  - NTT (mode=0): addr = brev7(k). bank0 holds index 2*addr, bank1 holds index 2*addr+1.
  - INTT (mode=1): addr = k. bank0 holds index addr, bank1 holds index addr+128.
- FSM states: IDLE, FILL, DRAIN.
  - IDLE: in_valid=1 -> write pair as k=0, latch mode into mode_q, k<=1, go to FILL.
  - FILL: each in_valid=1 writes at k, k<=k+1. Gaps (in_valid=0) hold k. Write at k==N_PAIRS-1 -> DRAIN next cycle, k<=0. Changes on the mode pin during FILL are ignored.
  - DRAIN: r walks 0..255.
    - Read bank/addr derived from r and mode_q:
      - NTT: bank=r[0], addr=r[7:1].
      - INTT: bank=r[7], addr=r[6:0].
    - Banks are synchronous-read; one prefetch register.
    - First out_valid asserts 2 cycles after the cycle of the 128th write.
    - While out_valid=1 and out_ready=0, out_data/out_idx/out_last hold stable.
    - With out_ready held high, throughput is 1 beat/cycle, with no bubbles after the first beat.
    - Handshake on out_idx==255 -> IDLE; out_valid=0 the next cycle.
    - A new in_valid is accepted from that IDLE cycle on.
- in_valid during DRAIN: pair dropped, buffer untouched, overflow<=1 (sticky until reset).
- Simultaneous last drain handshake and in_valid in the same cycle: the pair is dropped and overflow is set.
- busy = (state!=IDLE).

Optional Feature:
- Macro: NTT_OUT_COLLECTOR_RANGE_CHECK_EN.
- Defined: adds output range_err (1 bit, sticky, reset 0).
  - Set when an accepted pair has i1>=3329 or i2>=3329 (KYBER_Q).
  - Data is still stored unmodified.
- Undefined: port and logic are absent; there is no range checking.

Decomposition:
- kyber_pkg holds:
  - KYBER_Q=3329, KYBER_N=256, COEF_W=12.
  - Mode constants MODE_NTT=0, MODE_INTT=1.
  - Collector state encoding.
  - Function brev7 (7-bit bit reversal).
- Sub-module coef_bank:
  - 128 x COEF_W simple dual-port RAM, one write port, one synchronous-read port.
  - Instantiated twice.
- The FSM, counters and output register stay in ntt_out_collector.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, busy=0, overflow=0; no writes.
- INTT ordering: mode=1, 128 consecutive pairs i1=k, i2=k+128, out_ready=1 -> first out_valid 2 cycles after the last pair; beats out_idx=n, out_data=n for n=0..255; out_last only at 255.
- NTT bit-reversal: mode=0, pair k gives i1=2*brev7(k), i2=2*brev7(k)+1 (e.g. k=1: i1=128, i2=129) -> out_data==out_idx for all 256 beats.
- Back-pressure and input gaps: random 50% in_valid gaps during FILL, random 50% out_ready during DRAIN -> same 256 beats in order, outputs stable while stalled.
- Overflow: one extra pair while in DRAIN -> overflow=1 and stays 1; drained data is unchanged from the scenario-2 pattern.
- Reset mid-FILL: rst pulse after k=60 -> busy=0; next full INTT fill drains correctly. With NTT_OUT_COLLECTOR_RANGE_CHECK_EN defined, one pair i1=3329 -> range_err=1.
